note_source_arbiter: RTL
========================

// Module: note_source_arbiter
// PURPOSE
//  Parametrised successor to the buzzer note selector. Picks one of four note sources
//   (pins, UART, pins, database) by mode and registers the result.
//  Adds: UART byte decode with hold timer, one-hot sanitising, and a silent gap on mode change.
//  Drives the buzzer tone generator; sits between the input/UART/memory blocks and the buzzer.
// PARAMETERS
//  NOTE_W    10        one-hot note width (bit i = note i+1); 2..32
//  MUTE_CYC  1000      silent cycles forced after any mode change; >=1
//  HOLD_CYC  50000000  cycles a UART note is held after its byte arrives; >=1
//  SUS_CYC   5000000   sustain length when SUSTAIN_EN is defined; >=1
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous reset, active-low
//  mode        in   2       0=FREE 1=UART 2=LEARN 3=PLAY
//  pin_note    in   NOTE_W  key pins (level)
//  uart_byte   in   8       received note code
//  uart_valid  in   1       one-cycle strobe; qualifies uart_byte
//  db_note     in   NOTE_W  database/playback note (level)
//  note_out    out  NOTE_W  registered one-hot note; 0 = rest
//  muting      out  1       high while the mode-change gap is active
//  note_chg    out  1       one-cycle pulse when note_out changes value
// BEHAVIOUR
//  Reset (rst=0, async): note_out=0, muting=0, note_chg=0, UART note=0, hold counter=0,
//   sustain state cleared, mode_q=mode sampled at the first clock after release.
//  Source select: FREE and LEARN use pin_note, UART uses uart_note_q, PLAY uses db_note.
//  Sanitise: when the selected value has more than one bit set, keep only the lowest-index set bit.
//  Latency: note_out = sanitised selection one clk later (1 cycle). No combinational in->out path.
//  UART decode: on uart_valid, code k:
//   k=0 -> uart_note_q=0, hold counter cleared.
//   1<=k<=NOTE_W -> uart_note_q=1<<(k-1), hold counter loaded with HOLD_CYC.
//   k>NOTE_W -> ignored; the state does not change.
//   Each cycle the counter is nonzero it decrements. On reaching 0, uart_note_q is cleared.
//   A new valid byte during the hold restarts the hold (retrigger).
//   Decode runs in every mode, so the UART note is ready when UART mode is entered.
//  FSM states are RUN and MUTE:
//   RUN: if mode != mode_q -> MUTE, counter=MUTE_CYC-1, note_out=0, muting=1, mode_q<=mode.
//   MUTE: note_out held at 0. A further mode change reloads the counter and updates mode_q.
//     When the counter reaches 0 -> RUN, muting=0. The next cycle resumes normal selection.
//   A mode change at the same moment as uart_valid: the byte is decoded normally.
//   The gap still applies.
//  note_chg: registered pulse, 1 cycle after note_out differs from its previous value.
//   Also pulses on the transition to 0 at mute entry.
//  Counters are sized $clog2(max param + 1) bits. They saturate at 0 and never wrap.
// CONFIGURATION
//  SUSTAIN_EN defined:
//   In RUN, if the selected source goes 0 after a nonzero note, note_out holds the last note
//    for SUS_CYC cycles, then goes 0.
//   A new nonzero note replaces it at once.
//   Sustain is cleared on entering MUTE.
//  SUSTAIN_EN undefined: a source going 0 gives note_out=0 one cycle later. No sustain logic is built.
// TESTING  (use small params: MUTE_CYC=4 HOLD_CYC=8 SUS_CYC=3 NOTE_W=10)
//  1 Reset: rst=0 mid-run -> note_out=0, muting=0, note_chg=0 at once, with no clock edge.
//  2 FREE, pin_note=10'b0000000100 -> note_out=0x004 next cycle, note_chg pulses once.
//    Then pin_note=0x00C -> note_out=0x004 (lowest-bit sanitise).
//  3 UART, uart_byte=3 strobe -> note_out=0x004 for 8 cycles, then 0.
//    Byte 12 -> no change. Retrigger at cycle 5 extends the hold by 8 from the retrigger.
//  4 PLAY with db_note=0x200, switch to FREE with pin_note=0x001 -> 4 cycles of 0 with muting=1.
//    Then note_out=0x001. A second switch during the gap restarts the 4-cycle count.
//  5 PLAY, db_note 0x010 -> 0:
//    With SUSTAIN_EN: 0x010 is held 3 extra cycles, then 0.
//    Without SUSTAIN_EN: 0 in 1 cycle.
//  6 Random: mode, pins, bytes and db for 10k cycles against a reference model.
//    Check note_out is one-hot or zero and matches the model every cycle.

Source files
------------

// File: rtl/note_source_arbiter.sv
// rtl/note_source_arbiter.sv - mode-selected, sanitised, registered buzzer note source
//
// Picks one of four note sources by mode, keeps only the lowest set bit and
// registers the result for the buzzer tone generator. A UART byte decoder holds
// each received note for HOLD_CYC cycles. Every mode change forces a silent gap
// of MUTE_CYC cycles.
// Optional feature: define SUSTAIN_EN to hold the last note for SUS_CYC cycles
// after the selected source drops to zero.
//
// Ports:
//   clk        in   1       system clock
//   rst        in   1       asynchronous reset, active-low
//   mode       in   2       0=FREE 1=UART 2=LEARN 3=PLAY
//   pin_note   in   NOTE_W  key pins (level)
//   uart_byte  in   8       received note code (0=rest, k=note k)
//   uart_valid in   1       one-cycle strobe qualifying uart_byte
//   db_note    in   NOTE_W  database/playback note (level)
//   note_out   out  NOTE_W  registered one-hot note, 0 = rest
//   muting     out  1       high while the mode-change gap is active
//   note_chg   out  1       high for the first cycle note_out shows a new value

module note_source_arbiter #(
    parameter int NOTE_W   = 10,
    parameter int MUTE_CYC = 1000,
    parameter int HOLD_CYC = 50000000,
    parameter int SUS_CYC  = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [NOTE_W-1:0] pin_note,
    input  logic [7:0]        uart_byte,
    input  logic              uart_valid,
    input  logic [NOTE_W-1:0] db_note,
    output logic [NOTE_W-1:0] note_out,
    output logic              muting,
    output logic              note_chg
);

    if (NOTE_W < 2 || NOTE_W > 32 || MUTE_CYC < 1 || HOLD_CYC < 1 || SUS_CYC < 1) begin : g_bad_params
        $error("note_source_arbiter: parameter out of range");
    end

    localparam int MUTE_W = $clog2(MUTE_CYC + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_CYC - 1);
    localparam logic [MUTE_W-1:0] MUTE_ONE  = MUTE_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [NOTE_W-1:0] NOTE_ONE  = NOTE_W'(1);
    localparam logic [7:0]        NOTE_MAX  = 8'(NOTE_W);

    typedef enum logic {RUN, MUTE} state_t;

    state_t              state_q, state_d;
    logic [MUTE_W-1:0]   mute_cnt_q, mute_cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic                started_q;
    logic [NOTE_W-1:0]   note_d;
    logic                muting_d;
    logic                mode_change;

    logic [NOTE_W-1:0]   uart_note_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [NOTE_W-1:0]   sel_raw;
    logic [NOTE_W-1:0]   sel;

`ifdef SUSTAIN_EN
    localparam int SUS_W = $clog2(SUS_CYC + 1);
    localparam logic [SUS_W-1:0] SUS_LOAD = SUS_W'(SUS_CYC - 1);
    localparam logic [SUS_W-1:0] SUS_ONE  = SUS_W'(1);
    logic               sus_act_q, sus_act_d;
    logic [SUS_W-1:0]   sus_cnt_q, sus_cnt_d;
`endif

    // UART decode runs in every mode so the note is ready when UART mode starts.
    // Codes above NOTE_W are treated as if no byte arrived.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_note_q <= '0;
            hold_cnt_q  <= '0;
        end else if (uart_valid && uart_byte == 8'd0) begin
            uart_note_q <= '0;
            hold_cnt_q  <= '0;
        end else if (uart_valid && uart_byte <= NOTE_MAX) begin
            uart_note_q <= NOTE_ONE << (uart_byte - 8'd1);
            hold_cnt_q  <= HOLD_LOAD;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_q <= hold_cnt_q - HOLD_ONE;
            if (hold_cnt_q == HOLD_ONE) begin
                uart_note_q <= '0;
            end
        end
    end

    always_comb begin
        case (mode)
            2'd1:    sel_raw = uart_note_q;
            2'd3:    sel_raw = db_note;
            default: sel_raw = pin_note;
        endcase
        // x & -x isolates the lowest set bit
        sel = sel_raw & (~sel_raw + NOTE_ONE);
    end

    // mode_q only becomes meaningful after the first clock out of reset, so no
    // gap is triggered by whatever mode is present at release.
    assign mode_change = started_q && (mode != mode_q);

    always_comb begin
        state_d    = state_q;
        mute_cnt_d = mute_cnt_q;
        mode_d     = started_q ? mode_q : mode;
        note_d     = note_out;
        muting_d   = muting;
`ifdef SUSTAIN_EN
        sus_act_d  = sus_act_q;
        sus_cnt_d  = sus_cnt_q;
`endif
        case (state_q)
            RUN: begin
                if (mode_change) begin
                    state_d    = MUTE;
                    mute_cnt_d = MUTE_LOAD;
                    mode_d     = mode;
                    note_d     = '0;
                    muting_d   = 1'b1;
`ifdef SUSTAIN_EN
                    sus_act_d  = 1'b0;
`endif
                end else begin
`ifdef SUSTAIN_EN
                    if (sel != '0) begin
                        note_d    = sel;
                        sus_act_d = 1'b0;
                    end else if (note_out != '0) begin
                        // first zero cycle arms the sustain; note_out holds meanwhile
                        if (!sus_act_q) begin
                            sus_act_d = 1'b1;
                            sus_cnt_d = SUS_LOAD;
                        end else if (sus_cnt_q == '0) begin
                            note_d    = '0;
                            sus_act_d = 1'b0;
                        end else begin
                            sus_cnt_d = sus_cnt_q - SUS_ONE;
                        end
                    end else begin
                        note_d    = '0;
                        sus_act_d = 1'b0;
                    end
`else
                    note_d = sel;
`endif
                end
            end
            MUTE: begin
                note_d = '0;
                if (mode_change) begin
                    mute_cnt_d = MUTE_LOAD;
                    mode_d     = mode;
                end else if (mute_cnt_q == '0) begin
                    state_d  = RUN;
                    muting_d = 1'b0;
                end else begin
                    mute_cnt_d = mute_cnt_q - MUTE_ONE;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            mute_cnt_q <= '0;
            mode_q     <= 2'd0;
            started_q  <= 1'b0;
            note_out   <= '0;
            muting     <= 1'b0;
            note_chg   <= 1'b0;
`ifdef SUSTAIN_EN
            sus_act_q  <= 1'b0;
            sus_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mute_cnt_q <= mute_cnt_d;
            mode_q     <= mode_d;
            started_q  <= 1'b1;
            note_out   <= note_d;
            muting     <= muting_d;
            note_chg   <= (note_d != note_out);
`ifdef SUSTAIN_EN
            sus_act_q  <= sus_act_d;
            sus_cnt_q  <= sus_cnt_d;
`endif
        end
    end

endmodule
